id_ex_stage_reg: RTL
====================

Name: id_ex_stage_reg

Overview:
- Pipeline register between the Decode (ID) stage and the Execute (EX) stage of the 32-bit ARM pipeline.
- Captures the decoded control bundle (WB_EN, MEM_R, MEM_W, B, S, EX_CMD), operand values, immediate fields, destination register and status flags.
- Presents the captured values to EX one cycle later.
- Supports stall (freeze), branch flush, and condition-fail bubble insertion, so EX never sees a partially updated instruction.

Parameters:
- DATA_W, 32, width of PC and register operand values
- REG_ADDR_W, 4, register-file address width
- CMD_W, 4, EX_CMD width

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-high
- flush  in  1  branch taken in EX; kill the instruction entering EX next cycle
- freeze  in  1  hazard stall; hold all outputs
- valid_in  in  1  ID holds a real instruction
- cond_pass_in  in  1  condition-code check passed for the ID instruction
- WB_EN_in, MEM_R_in, MEM_W_in, B_in, S_in  in  1 each  decoded control bits
- EX_CMD_in  in  CMD_W  ALU command
- PC_in  in  DATA_W  PC+4 of the instruction
- Val_Rn_in, Val_Rm_in  in  DATA_W  register operands
- imm_in  in  1  I bit
- shift_operand_in  in  12  shifter operand field
- signed_imm_24_in  in  24  branch offset
- Dest_in  in  REG_ADDR_W  destination register
- SR_in  in  4  status flags {N,Z,C,V}
- valid_out  out  1  EX holds a real instruction
- WB_EN, MEM_R, MEM_W, B, S, EX_CMD, PC, Val_Rn, Val_Rm, imm, shift_operand, signed_imm_24, Dest, SR  out  (widths as inputs)  registered copies

Behaviour:
- Priority per rising edge: rst (asynchronous) > flush > freeze > cond-fail bubble > load.
- Reset:
  - Every output goes to 0 immediately, regardless of clk.
  - After rst deasserts, the first edge behaves per the priority above.
- Load (valid_in=1, cond_pass_in=1, no flush/freeze): every output equals its _in value, latency 1 cycle; valid_out=1.
- Cond-fail bubble (valid_in=1, cond_pass_in=0):
  - valid_out, WB_EN, MEM_R, MEM_W, B and S load 0.
  - EX_CMD, data fields, Dest, PC and SR still load, for debug visibility only.
  - No side effect may occur in EX or later stages.
- valid_in=0: same as the cond-fail bubble.
- Flush:
  - valid_out, WB_EN, MEM_R, MEM_W, B, S and EX_CMD clear to 0.
  - Data fields clear to 0.
  - Flush overrides freeze: a stall during a taken branch still kills the instruction.
- Freeze without flush: every output holds its previous value, including valid_out. Input changes during freeze are ignored.
- Reset mid-operation: the instruction in the register is discarded with no partial state.
- No internal state other than the registered outputs.

Optional Feature:
- Macro: FORWARDING_EN.
- When defined:
  - Adds inputs src1_in and src2_in (REG_ADDR_W each) and registered outputs src1 and src2.
  - src1/src2 are loaded on load, cond-fail bubble and valid_in=0 edges (same as the data fields); cleared by rst and flush; held on freeze.
  - Adds output fwd_ok, 1 bit = valid_out, for consumption by the forwarding unit.
- When undefined: these ports do not exist and the behaviour is unchanged.

Decomposition:
- Shared package arm_pkg:
  - EX_CMD encodings (MOV 0001, MVN 1001, ADD 0010, ADC 0011, SUB 0100, SBC 0101, AND 0110, ORR 0111, EOR 1000, CMP 1100, TST 1110, LDR/STR 1010).
  - Mode codes (ARITH 00, MEM 01, BRANCH 10).
  - DATA_W and REG_ADDR_W defaults.
- One sub-module, pipe_field_reg: parameterised width, async clear, sync clear, enable. Instantiated once per field group (control group, data group).

Test Plan:
- rst=1 mid-stream with outputs nonzero -> all outputs 0 within the same cycle, before the next clk edge.
- Load ADD: EX_CMD_in=0010, WB_EN_in=1, Val_Rn_in=0x00000005, Val_Rm_in=0x00000003, Dest_in=4, cond_pass_in=1 -> next cycle EX_CMD=0010, WB_EN=1, Val_Rn=5, Val_Rm=3, Dest=4, valid_out=1.
- STR with cond_pass_in=0, MEM_W_in=1 -> MEM_W=0, WB_EN=0, valid_out=0; Dest still loaded.
- freeze=1 for 3 cycles while inputs change to an LDR -> outputs keep the prior ADD values; on the first edge after freeze drops, the LDR appears with MEM_R=1, EX_CMD=1010.
- freeze=1 and flush=1 on the same edge -> valid_out=0, WB_EN=0, B=0, EX_CMD=0000.
- Branch: B_in=1, signed_imm_24_in=0xFFFFFE, PC_in=0x00000020 -> B=1, signed_imm_24=0xFFFFFE, PC=0x20; next-cycle flush=1 -> B=0, valid_out=0.

Source files
------------

// File: rtl/arm_pkg.sv
// ----------------------------------------------------------------------------
// arm_pkg
//   Shared definitions for the 32-bit ARM pipeline:
//     - default datapath widths (ARM_DATA_W, ARM_REG_ADDR_W, ARM_CMD_W)
//     - EX_CMD ALU command encodings
//     - instruction mode codes
//     - the control bundle carried between pipeline stages, and a helper that
//       squashes its side-effect bits for bubbles
// ----------------------------------------------------------------------------
package arm_pkg;

  localparam int ARM_DATA_W     = 32;
  localparam int ARM_REG_ADDR_W = 4;
  localparam int ARM_CMD_W      = 4;

  typedef enum logic [3:0] {
    CMD_NOP = 4'b0000,
    CMD_MOV = 4'b0001,
    CMD_ADD = 4'b0010,
    CMD_ADC = 4'b0011,
    CMD_SUB = 4'b0100,
    CMD_SBC = 4'b0101,
    CMD_AND = 4'b0110,
    CMD_ORR = 4'b0111,
    CMD_EOR = 4'b1000,
    CMD_MVN = 4'b1001,
    CMD_MEM = 4'b1010,  // LDR and STR share the address-add command
    CMD_CMP = 4'b1100,
    CMD_TST = 4'b1110
  } ex_cmd_e;

  typedef enum logic [1:0] {
    MODE_ARITH  = 2'b00,
    MODE_MEM    = 2'b01,
    MODE_BRANCH = 2'b10
  } mode_e;

  // Every bit here can cause an architectural side effect downstream
  // (valid marks the slot as a real instruction).
  typedef struct packed {
    logic valid;
    logic wb_en;
    logic mem_r;
    logic mem_w;
    logic b;
    logic s;
  } ctrl_t;

  // A dead instruction (invalid or failed condition) must travel as a bubble.
  function automatic ctrl_t squash_ctrl(input logic live, input ctrl_t c);
    squash_ctrl = live ? c : '0;
  endfunction

endpackage

// File: rtl/pipe_field_reg.sv
// ----------------------------------------------------------------------------
// pipe_field_reg
//   Generic pipeline field register used for each field group of a stage
//   register. Priority: async clear (rst) > sync clear (clr) > load (en) > hold.
//   Ports:
//     clk  - rising-edge clock
//     rst  - asynchronous clear, active-high
//     clr  - synchronous clear (takes precedence over en)
//     en   - load enable; when low the register holds
//     d    - next value
//     q    - registered value
// ----------------------------------------------------------------------------
module pipe_field_reg #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] data_d;
  logic [W-1:0] data_q;

  always_comb begin
    // NOTE: default assignment first so every path assigns data_d; without it
    // the hold case would infer a latch instead of feeding back the flop.
    data_d = data_q;
    if (clr) begin
      data_d = '0;
    end else if (en) begin
      data_d = d;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so all
  // flops sample their inputs from the same pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q = data_q;

endmodule

// File: rtl/id_ex_stage_reg.sv
// ----------------------------------------------------------------------------
// id_ex_stage_reg
//   ID -> EX pipeline register. Captures the decoded control bundle, operands,
//   immediate fields, destination and status flags, and presents them to EX
//   one cycle later.
//   Edge priority: rst (async) > flush > freeze > bubble > load.
//     flush  : everything (control and data) clears to 0, even during freeze
//     freeze : every output holds
//     bubble : valid_in=0 or cond_pass_in=0 -> valid_out/WB_EN/MEM_R/MEM_W/B/S
//              load 0; EX_CMD and data fields still load for debug visibility
//   Ports:
//     clk, rst                 clock, async active-high reset
//     flush, freeze            pipeline control
//     valid_in, cond_pass_in   liveness of the ID instruction
//     *_in                     decoded fields from ID
//     valid_out and outputs    registered copies for EX
//   Optional build macro FORWARDING_EN adds src1_in/src2_in, registered
//   src1/src2 (handled like the data fields) and fwd_ok (= valid_out).
// ----------------------------------------------------------------------------
module id_ex_stage_reg
  import arm_pkg::*;
#(
  parameter int DATA_W     = ARM_DATA_W,
  parameter int REG_ADDR_W = ARM_REG_ADDR_W,
  parameter int CMD_W      = ARM_CMD_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  freeze,
  input  logic                  valid_in,
  input  logic                  cond_pass_in,
  input  logic                  WB_EN_in,
  input  logic                  MEM_R_in,
  input  logic                  MEM_W_in,
  input  logic                  B_in,
  input  logic                  S_in,
  input  logic [CMD_W-1:0]      EX_CMD_in,
  input  logic [DATA_W-1:0]     PC_in,
  input  logic [DATA_W-1:0]     Val_Rn_in,
  input  logic [DATA_W-1:0]     Val_Rm_in,
  input  logic                  imm_in,
  input  logic [11:0]           shift_operand_in,
  input  logic [23:0]           signed_imm_24_in,
  input  logic [REG_ADDR_W-1:0] Dest_in,
  input  logic [3:0]            SR_in,
`ifdef FORWARDING_EN
  input  logic [REG_ADDR_W-1:0] src1_in,
  input  logic [REG_ADDR_W-1:0] src2_in,
  output logic [REG_ADDR_W-1:0] src1,
  output logic [REG_ADDR_W-1:0] src2,
  output logic                  fwd_ok,
`endif
  output logic                  valid_out,
  output logic                  WB_EN,
  output logic                  MEM_R,
  output logic                  MEM_W,
  output logic                  B,
  output logic                  S,
  output logic [CMD_W-1:0]      EX_CMD,
  output logic [DATA_W-1:0]     PC,
  output logic [DATA_W-1:0]     Val_Rn,
  output logic [DATA_W-1:0]     Val_Rm,
  output logic                  imm,
  output logic [11:0]           shift_operand,
  output logic [23:0]           signed_imm_24,
  output logic [REG_ADDR_W-1:0] Dest,
  output logic [3:0]            SR
);

  localparam int BASE_W = CMD_W + 3 * DATA_W + 1 + 12 + 24 + REG_ADDR_W + 4;
`ifdef FORWARDING_EN
  localparam int DATA_GRP_W = BASE_W + 2 * REG_ADDR_W;
`else
  localparam int DATA_GRP_W = BASE_W;
`endif

  logic                  live;
  ctrl_t                 ctrl_next;
  ctrl_t                 ctrl_out;
  logic [DATA_GRP_W-1:0] data_next;
  logic [DATA_GRP_W-1:0] data_out;

  always_comb begin
    live      = valid_in & cond_pass_in;
    ctrl_next = squash_ctrl(live, '{valid: 1'b1, wb_en: WB_EN_in, mem_r: MEM_R_in,
                                    mem_w: MEM_W_in, b: B_in, s: S_in});
`ifdef FORWARDING_EN
    data_next = {src1_in, src2_in,
                 EX_CMD_in, PC_in, Val_Rn_in, Val_Rm_in, imm_in,
                 shift_operand_in, signed_imm_24_in, Dest_in, SR_in};
`else
    data_next = {EX_CMD_in, PC_in, Val_Rn_in, Val_Rm_in, imm_in,
                 shift_operand_in, signed_imm_24_in, Dest_in, SR_in};
`endif
  end

  // Flush is the sync clear so it wins over freeze (freeze only drops en).
  pipe_field_reg #(.W($bits(ctrl_t))) u_ctrl_reg (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .en  (~freeze),
    .d   (ctrl_next),
    .q   (ctrl_out)
  );

  pipe_field_reg #(.W(DATA_GRP_W)) u_data_reg (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .en  (~freeze),
    .d   (data_next),
    .q   (data_out)
  );

  assign valid_out = ctrl_out.valid;
  assign WB_EN     = ctrl_out.wb_en;
  assign MEM_R     = ctrl_out.mem_r;
  assign MEM_W     = ctrl_out.mem_w;
  assign B         = ctrl_out.b;
  assign S         = ctrl_out.s;

`ifdef FORWARDING_EN
  assign {src1, src2,
          EX_CMD, PC, Val_Rn, Val_Rm, imm,
          shift_operand, signed_imm_24, Dest, SR} = data_out;
  assign fwd_ok = ctrl_out.valid;
`else
  assign {EX_CMD, PC, Val_Rn, Val_Rm, imm,
          shift_operand, signed_imm_24, Dest, SR} = data_out;
`endif

endmodule
